// File: rtl/clk_div_monitor.sv
// -----------------------------------------------------------------------------
// clk_div_monitor
//
// Checks a divided clock by sampling it as ordinary data in the clk_in domain.
// The block measures the period and the high time of sig_in in clk_in cycles.
// It compares both against exp_period / exp_high within +/-TOL. A mismatch, or
// a stuck input that saturates the period counter, raises a sticky error and
// bumps a saturating error counter.
//
// Ports
//   clk_in      in   1  system clock (sole clock)
//   rst         in   1  asynchronous, active-high reset
//   sig_in      in   1  divided clock under test, treated as data
//   enable      in   1  1 = measure, 0 = return to IDLE (outputs hold)
//   exp_period  in   W  expected period in clk_in cycles
//   exp_high    in   W  expected high time in clk_in cycles
//   clear_err   in   1  synchronous clear of err / err_count
//   period      out  W  last completed period measurement
//   high_time   out  W  last completed high-time measurement
//   meas_valid  out  1  one-cycle pulse when period/high_time update
//   err         out  1  sticky: mismatch or timeout seen
//   timeout     out  1  one-cycle pulse: period counter saturated
//   err_count   out  8  number of error events, saturates at 255
// -----------------------------------------------------------------------------
module clk_div_monitor #(
    parameter int W           = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TOL         = 0
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         sig_in,
    input  logic         enable,
    input  logic [W-1:0] exp_period,
    input  logic [W-1:0] exp_high,
    input  logic         clear_err,
    output logic [W-1:0] period,
    output logic [W-1:0] high_time,
    output logic         meas_valid,
    output logic         err,
    output logic         timeout,
    output logic [7:0]   err_count
);

    typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

    localparam logic [W-1:0] CNT_MAX = '1;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d;
    logic                   s, rise, fall;
    logic [W-1:0]           per_q, per_d;
    logic [W-1:0]           hi_q, hi_d;
    logic                   report, time_out, mismatch, err_event;

    function automatic logic [W-1:0] abs_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // ---------------- Synchroniser and edge detector ----------------
    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    // NOTE: the sync chain is a handful of flops, not a memory, so it is reset
    // like any other state; that keeps a spurious rise from firing after reset.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= (sync_q << 1) | SYNC_STAGES'(sig_in);
            s_d    <= s;
        end
    end

    // ---------------- FSM: state register ----------------
    // NOTE: every clocked block uses non-blocking assignments so all flops
    // sample pre-edge values regardless of process ordering.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next-state logic ----------------
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: state_d = ARM;
                ARM:  if (rise) state_d = HIGH;
                HIGH: begin
                    if (fall)                  state_d = LOW;
                    else if (per_q == CNT_MAX) state_d = ARM;
                end
                LOW: begin
                    if (rise)                  state_d = HIGH;
                    else if (per_q == CNT_MAX) state_d = ARM;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // ---------------- FSM: output decode ----------------
    // A report happens on a rise seen in LOW. A timeout happens when the
    // period counter is already full and the edge that would end the current
    // phase has not arrived.
    always_comb begin
        report   = enable && (state_q == LOW) && rise;
        time_out = enable && (per_q == CNT_MAX) &&
                   (((state_q == HIGH) && !fall) || ((state_q == LOW) && !rise));
        mismatch = report && ((abs_diff(per_q, exp_period) > W'(TOL)) ||
                              (abs_diff(hi_q,  exp_high)   > W'(TOL)));
        err_event = mismatch || time_out;
    end

    // ---------------- Counter next values ----------------
    always_comb begin
        per_d = per_q;
        hi_d  = hi_q;
        if (!enable || time_out) begin
            per_d = '0;
            hi_d  = '0;
        end else begin
            unique case (state_q)
                ARM: if (rise) begin
                    per_d = W'(1);
                    hi_d  = W'(1);
                end
                HIGH: begin
                    // A fall on the last count holds at full scale; the
                    // following LOW cycle then times out.
                    if (per_q != CNT_MAX) per_d = per_q + 1'b1;
                    if (!fall)            hi_d  = hi_q + 1'b1;
                end
                LOW: begin
                    if (rise) begin
                        per_d = W'(1);
                        hi_d  = W'(1);
                    end else begin
                        per_d = per_q + 1'b1;
                    end
                end
                default: begin
                    per_d = '0;
                    hi_d  = '0;
                end
            endcase
        end
    end

    // ---------------- Counters and registered outputs ----------------
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            per_q      <= '0;
            hi_q       <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            err        <= 1'b0;
            err_count  <= 8'd0;
        end else begin
            per_q      <= per_d;
            hi_q       <= hi_d;
            meas_valid <= report;
            timeout    <= time_out;
            if (report) begin
                period    <= per_q;
                high_time <= hi_q;
            end
            // A clear that coincides with a new error keeps that one error.
            if (clear_err) begin
                err       <= err_event;
                err_count <= err_event ? 8'd1 : 8'd0;
            end else if (err_event) begin
                err <= 1'b1;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// -----------------------------------------------------------------------------
// tb_clk_div_monitor
//
// Directed bench for clk_div_monitor (W=8, SYNC_STAGES=2, TOL=0). A table of
// steady waveforms checks the measurement and compare path. Hand-written
// sequences cover timeout, enable drop, clear/error collision, err_count
// saturation and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_clk_div_monitor;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       sig_in;
    logic       enable;
    logic [7:0] exp_period;
    logic [7:0] exp_high;
    logic       clear_err;
    logic [7:0] period;
    logic [7:0] high_time;
    logic       meas_valid;
    logic       err;
    logic       timeout;
    logic [7:0] err_count;

    int tests  = 0;
    int fails  = 0;
    int mv_cnt = 0;
    int to_cnt = 0;

    clk_div_monitor #(.W(8), .SYNC_STAGES(2), .TOL(0)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .sig_in     (sig_in),
        .enable     (enable),
        .exp_period (exp_period),
        .exp_high   (exp_high),
        .clear_err  (clear_err),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .err        (err),
        .timeout    (timeout),
        .err_count  (err_count)
    );

    always #5 clk_in = ~clk_in;

    // Pulse monitor: samples 1 time unit after each rising edge.
    always @(posedge clk_in) begin
        #1;
        if (meas_valid) mv_cnt++;
        if (timeout)    to_cnt++;
    end

    typedef struct {
        int hi;
        int lo;
        int ep;
        int eh;
        int want_p;
        int want_h;
        int want_err;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One clock; inputs are driven and outputs sampled 2 units after the edge.
    task automatic step();
        @(posedge clk_in);
        #2;
    endtask

    task automatic run_stream(input int hi, input int lo, input int n, input int pad);
        for (int p = 0; p < n; p++) begin
            sig_in = 1'b1;
            repeat (hi) step();
            sig_in = 1'b0;
            repeat (lo) step();
        end
        repeat (pad) step();
    endtask

    // Waits for a timeout pulse with sig_in held high; returns cycles taken.
    task automatic wait_timeout(output int n);
        n = 0;
        while (n < 400 && timeout !== 1'b1) begin
            step();
            n++;
        end
    endtask

    int mv0, to0, n;

    initial begin
        vecs[0] = '{hi: 1,  lo: 1,  ep: 2,  eh: 1,  want_p: 2,  want_h: 1,  want_err: 0};
        vecs[1] = '{hi: 13, lo: 13, ep: 26, eh: 13, want_p: 26, want_h: 13, want_err: 0};
        vecs[2] = '{hi: 2,  lo: 2,  ep: 4,  eh: 2,  want_p: 4,  want_h: 2,  want_err: 0};
        vecs[3] = '{hi: 3,  lo: 5,  ep: 8,  eh: 3,  want_p: 8,  want_h: 3,  want_err: 0};
        vecs[4] = '{hi: 1,  lo: 3,  ep: 4,  eh: 2,  want_p: 4,  want_h: 1,  want_err: 1};
        vecs[5] = '{hi: 5,  lo: 2,  ep: 8,  eh: 5,  want_p: 7,  want_h: 5,  want_err: 1};
        vecs[6] = '{hi: 12, lo: 13, ep: 26, eh: 13, want_p: 25, want_h: 12, want_err: 1};

        rst = 1'b1; sig_in = 1'b0; enable = 1'b0; clear_err = 1'b0;
        exp_period = 8'd0; exp_high = 8'd0;
        step(); step();
        check("reset period",     period,     0);
        check("reset high_time",  high_time,  0);
        check("reset meas_valid", meas_valid, 0);
        check("reset err",        err,        0);
        check("reset timeout",    timeout,    0);
        check("reset err_count",  err_count,  0);
        rst = 1'b0;
        step();

        // ---------------- Table-driven steady waveforms ----------------
        for (int i = 0; i < 7; i++) begin
            enable = 1'b0; clear_err = 1'b1;
            exp_period = 8'(vecs[i].ep); exp_high = 8'(vecs[i].eh);
            step();
            clear_err = 1'b0; enable = 1'b1;
            repeat (4) step();
            mv0 = mv_cnt;
            run_stream(vecs[i].hi, vecs[i].lo, 3, 3);
            check($sformatf("vec%0d reports", i),   mv_cnt - mv0, 2);
            check($sformatf("vec%0d period", i),    period,       vecs[i].want_p);
            check($sformatf("vec%0d high_time", i), high_time,    vecs[i].want_h);
            check($sformatf("vec%0d err", i),       err,          vecs[i].want_err);
            check($sformatf("vec%0d err_count", i), err_count,    vecs[i].want_err ? 2 : 0);
        end

        // ---------------- Stuck-high timeout ----------------
        enable = 1'b0; clear_err = 1'b1;
        step();
        clear_err = 1'b0; enable = 1'b1;
        repeat (5) step();
        mv0 = mv_cnt; to0 = to_cnt;
        sig_in = 1'b1;
        wait_timeout(n);
        check("timeout latency", n, 258);
        check("timeout err", err, 1);
        check("timeout err_count", err_count, 1);
        repeat (300) step();
        check("timeout no repeat", to_cnt - to0, 1);
        check("timeout no meas_valid", mv_cnt - mv0, 0);
        sig_in = 1'b0;
        repeat (5) step();
        sig_in = 1'b1;
        wait_timeout(n);
        check("timeout after new rise", n, 258);
        check("timeout err_count 2", err_count, 2);
        sig_in = 1'b0;
        repeat (5) step();

        // ---------------- Enable dropped mid-HIGH ----------------
        enable = 1'b0; step();
        exp_period = 8'd4; exp_high = 8'd2; enable = 1'b1;
        repeat (4) step();
        mv0 = mv_cnt;
        run_stream(2, 2, 3, 0);
        sig_in = 1'b1;
        repeat (3) step();
        check("div4 reports", mv_cnt - mv0, 3);
        check("div4 period", period, 4);
        enable = 1'b0;
        mv0 = mv_cnt;
        step();
        run_stream(2, 2, 3, 3);
        check("disabled no meas_valid", mv_cnt - mv0, 0);
        check("disabled period holds", period, 4);
        enable = 1'b1;
        repeat (2) step();
        mv0 = mv_cnt;
        run_stream(2, 2, 1, 3);
        check("re-enable first rise only arms", mv_cnt - mv0, 0);
        enable = 1'b0; step(); enable = 1'b1; repeat (2) step();
        mv0 = mv_cnt;
        run_stream(2, 2, 2, 3);
        check("re-enable report at second rise", mv_cnt - mv0, 1);
        check("re-enable period", period, 4);

        // ---------------- clear_err colliding with a mismatch ----------------
        enable = 1'b0; step();
        exp_period = 8'd4; exp_high = 8'd2; enable = 1'b1;
        repeat (4) step();
        sig_in = 1'b1; step();
        sig_in = 1'b0; repeat (3) step();
        sig_in = 1'b1; step();
        sig_in = 1'b0; step();
        clear_err = 1'b1; step();
        check("collide meas_valid", meas_valid, 1);
        check("collide high_time", high_time, 1);
        check("collide err", err, 1);
        check("collide err_count", err_count, 1);
        clear_err = 1'b0; enable = 1'b0; step();
        clear_err = 1'b1; step();
        clear_err = 1'b0;
        check("clear err", err, 0);
        check("clear err_count", err_count, 0);

        // ---------------- err_count saturation ----------------
        exp_period = 8'd3; exp_high = 8'd1; enable = 1'b1;
        repeat (4) step();
        mv0 = mv_cnt;
        run_stream(1, 1, 258, 3);
        check("sat reports", mv_cnt - mv0, 257);
        check("sat err_count", err_count, 255);

        // ---------------- Asynchronous reset mid-LOW ----------------
        enable = 1'b0; clear_err = 1'b1; step();
        clear_err = 1'b0;
        exp_period = 8'd6; exp_high = 8'd3; enable = 1'b1;
        repeat (4) step();
        run_stream(3, 3, 2, 2);
        check("pre-reset period", period, 6);
        #1 rst = 1'b1;
        #1;
        check("async rst period", period, 0);
        check("async rst high_time", high_time, 0);
        check("async rst err_count", err_count, 0);
        rst = 1'b0;
        repeat (2) step();
        mv0 = mv_cnt;
        run_stream(3, 3, 3, 3);
        check("post-reset reports", mv_cnt - mv0, 2);
        check("post-reset period", period, 6);
        check("post-reset high_time", high_time, 3);
        check("post-reset err", err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
